// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

    localparam int unsigned DEF_XLEN = 32;
    localparam int unsigned DEF_AW   = 5;

    localparam int unsigned REG_ZERO = 0;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: combinational one-hot grant from valids and last grant.
module rr_arb2
    import regfile_wb_arbiter_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        // Under contention, the requester that did not win last time goes next.
        if (valid[0] && (!valid[1] || last_grant == REQ1)) begin
            grant[0] = 1'b1;
        end else if (valid[1]) begin
            grant[1] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between two writeback sources and
// tracks registers awaiting a multi-cycle result.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned XLEN = DEF_XLEN,
    parameter int unsigned AW   = DEF_AW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [AW-1:0]        req0_rd,
    input  logic [XLEN-1:0]      req0_wd,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [AW-1:0]        req1_rd,
    input  logic [XLEN-1:0]      req1_wd,
    input  logic                 pend_set,
    input  logic [AW-1:0]        pend_rd,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_rd,
    output logic [XLEN-1:0]      rf_wd,
    output logic [(1<<AW)-1:0]   pending
);

    logic                 last_grant;
    logic [1:0]           grant;
    logic                 xfer;
    logic [AW-1:0]        sel_rd;
    logic [XLEN-1:0]      sel_wd;
    logic [(1<<AW)-1:0]   pend_next;

    rr_arb2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign xfer       = grant[0] | grant[1];
    assign sel_rd     = grant[1] ? req1_rd : req0_rd;
    assign sel_wd     = grant[1] ? req1_wd : req0_wd;

    // Clear before set so a fresh issue to the same register survives the writeback.
    always_comb begin
        pend_next = pending;
        if (xfer) begin
            pend_next[sel_rd] = 1'b0;
        end
        if (pend_set && pend_rd != '0) begin
            pend_next[pend_rd] = 1'b1;
        end
        pend_next[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we      <= 1'b0;
            rf_rd      <= '0;
            rf_wd      <= '0;
            pending    <= '0;
            last_grant <= REQ1;
        end else begin
            pending <= pend_next;
            if (xfer) begin
                rf_we      <= (sel_rd != '0);
                rf_rd      <= sel_rd;
                rf_wd      <= sel_wd;
                last_grant <= grant[1] ? REQ1 : REQ0;
            end else begin
                rf_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid;
    logic        req0_ready;
    logic [4:0]  req0_rd;
    logic [31:0] req0_wd;
    logic        req1_valid;
    logic        req1_ready;
    logic [4:0]  req1_rd;
    logic [31:0] req1_wd;
    logic        pend_set;
    logic [4:0]  pend_rd;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;
    logic [31:0] pending;

    int tests;
    int fails;

    regfile_wb_arbiter #(.XLEN(32), .AW(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_rd    (req0_rd),
        .req0_wd    (req0_wd),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_rd    (req1_rd),
        .req1_wd    (req1_wd),
        .pend_set   (pend_set),
        .pend_rd    (pend_rd),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_wd      (rf_wd),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        pend_set   = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        req0_valid = 1'b0; req0_rd = '0; req0_wd = '0;
        req1_valid = 1'b0; req1_rd = '0; req1_wd = '0;
        pend_set = 1'b0; pend_rd = '0;
        step(); step();
        chk("rst_we", rf_we, 0);
        chk("rst_rd", rf_rd, 0);
        chk("rst_wd", rf_wd, 0);
        chk("rst_pending", pending, 0);
        reset = 1'b0;
        step();

        // single req0 write, 1-cycle latency
        req0_valid = 1'b1; req0_rd = 5'd5; req0_wd = 32'hDEADBEEF;
        #1;
        chk("t1_ready0", req0_ready, 1);
        chk("t1_ready1", req1_ready, 0);
        step();
        idle();
        chk("t1_we", rf_we, 1);
        chk("t1_rd", rf_rd, 5);
        chk("t1_wd", rf_wd, 32'hDEADBEEF);
        step();
        chk("t1_we_drop", rf_we, 0);
        chk("t1_rd_hold", rf_rd, 5);

        // x0 write from req1: accepted, no rf write
        req1_valid = 1'b1; req1_rd = 5'd0; req1_wd = 32'hFFFFFFFF;
        #1;
        chk("x0_ready1", req1_ready, 1);
        chk("x0_ready0", req0_ready, 0);
        step();
        idle();
        chk("x0_we", rf_we, 0);
        chk("x0_wd", rf_wd, 32'hFFFFFFFF);
        chk("x0_pending", pending, 0);

        // contention: last grant was req1, so req0 first
        req0_valid = 1'b1; req0_rd = 5'd1; req0_wd = 32'h11;
        req1_valid = 1'b1; req1_rd = 5'd2; req1_wd = 32'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_ready0", req0_ready, (i % 2 == 0));
            chk("rr_ready1", req1_ready, (i % 2 == 1));
            step();
            chk("rr_we", rf_we, 1);
            chk("rr_rd", rf_rd, (i % 2 == 0) ? 1 : 2);
            chk("rr_wd", rf_wd, (i % 2 == 0) ? 32'h11 : 32'h22);
        end
        idle();
        step();

        // scoreboard set, clear, set-wins
        pend_set = 1'b1; pend_rd = 5'd7;
        step();
        pend_set = 1'b0;
        chk("sb_set7", pending, 32'h80);
        req1_valid = 1'b1; req1_rd = 5'd7; req1_wd = 32'h77;
        step();
        chk("sb_clr7", pending, 0);
        chk("sb_clr7_we", rf_we, 1);
        pend_set = 1'b1; pend_rd = 5'd7;
        step();
        idle();
        chk("sb_setwins", pending, 32'h80);
        chk("sb_setwins_rd", rf_rd, 7);

        pend_set = 1'b1; pend_rd = 5'd0;
        step();
        chk("sb_x0", pending, 32'h80);
        pend_rd = 5'd9;
        step();
        pend_set = 1'b0;
        chk("sb_set9", pending, 32'h280);
        pend_set = 1'b1; pend_rd = 5'd3;
        req0_valid = 1'b1; req0_rd = 5'd9; req0_wd = 32'h99;
        #1;
        chk("sb_mix_ready0", req0_ready, 1);
        step();
        idle();
        chk("sb_mix", pending, 32'h88);

        // async reset mid-cycle
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int r = 12; r < 16; r++) begin
            pend_set = 1'b1; pend_rd = 5'(r);
            step();
        end
        pend_set = 1'b0;
        chk("ar_pending_pre", pending, 32'h0000F000);
        req0_valid = 1'b1; req0_rd = 5'd20; req0_wd = 32'hABCD;
        step();
        chk("ar_we_pre", rf_we, 1);
        chk("ar_rd_pre", rf_rd, 20);
        req0_rd = 5'd21; req0_wd = 32'h1234;
        #1;
        chk("ar_ready0_pre", req0_ready, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_we", rf_we, 0);
        chk("ar_rd", rf_rd, 0);
        chk("ar_wd", rf_wd, 0);
        chk("ar_pending", pending, 0);
        idle();
        step();
        reset = 1'b0;
        step();
        chk("ar_we_post", rf_we, 0);

        req0_valid = 1'b1; req0_rd = 5'd4; req0_wd = 32'h44;
        req1_valid = 1'b1; req1_rd = 5'd6; req1_wd = 32'h66;
        #1;
        chk("post_ready0", req0_ready, 1);
        chk("post_ready1", req1_ready, 0);
        step();
        idle();
        chk("post_wd", rf_wd, 32'h44);
        chk("post_rd", rf_rd, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
